gcounter: RTL and testbench
===========================

// Module: gcounter
// PURPOSE
//   Free-running WIDTH-bit Gray-code counter for the power-analysis flow.
//   Each clock advances the count by one. Exactly one output bit toggles per
//   cycle, which minimises switching activity versus a binary counter.
//   Top-level leaf block with no handshake; q drives downstream logic and the
//   gate-level power traces.
// PARAMETERS
//   WIDTH  32  Counter/output width in bits; legal range 2..64.
// PORTS
//   clk    input   1      Rising-edge clock; the only clock.
//   reset  input   1      Synchronous, active-high reset.
//   q      output  WIDTH  Current count in reflected-binary Gray code (registered).
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high (ports clk, reset).
//   - State is a single WIDTH-bit register holding the Gray value; q is that
//     register directly, with no combinational output path.
//   - Reset: at any posedge with reset=1, q <= 0. Reset has priority over
//     counting. Asserting reset mid-count clears q on the next edge.
//   - Count: at posedge with reset=0, q <= G(B(q)+1), where:
//     * B() is Gray-to-binary: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i].
//     * G() is binary-to-Gray: g = b ^ (b>>1).
//     * The +1 is modulo 2^WIDTH.
//   - Latency: the first posedge after reset deasserts gives q=1.
//     Sequence from reset: 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,24,...
//   - Invariant: popcount(q_prev ^ q_next) == 1 on every counting edge.
//   - Wrap: when q = {1'b1,{WIDTH-1{1'b0}}} (binary 2^WIDTH-1), the next q is 0.
//     This is still a single-bit change; no flag, no stall.
//   - No X propagation after the first reset. Power-up value before reset is
//     undefined.
//   - Increment: binary conversion, add, and reconversion in one combinational
//     cone. No shadow binary register, so switching stays Gray-only.
// CONFIGURATION
//   GCOUNTER_BIN_EN
//     Defined:
//       * Adds output bin[WIDTH-1:0], which equals B(q) combinationally in the
//         same cycle.
//       * bin is 0 during and after reset.
//       * Adds no extra state registers.
//     Undefined:
//       * Port list is exactly clk, reset, q.
//       * The Gray-to-binary logic stays internal to the increment path.
// TESTING
//   1. Hold reset 3 cycles -> q==0 on every edge; q==0 at the first edge
//      after release is not allowed (must be 1).
//   2. Release reset, run 200 cycles -> q follows 0x1,0x3,0x2,0x6,0x7,0x5,
//      0x4,0xC,...; at cycle 200, B(q)==200 (q==0x000000AC).
//   3. Every counting edge -> exactly one bit of q differs from its previous
//      value (checked with a $countones monitor).
//   4. WIDTH=4, run 16 cycles from reset -> q goes 8 then 0. Wrap is clean and
//      the single-bit invariant holds across the wrap.
//   5. Assert reset for 1 cycle at count 57 (q==0x25) -> next edge q==0;
//      counting then restarts 1,3,2.
//   6. With GCOUNTER_BIN_EN -> bin==0,1,2,3,... in lockstep with q; matches
//      B(q) on every cycle for 200 cycles.

Source files
------------

// File: rtl/gcounter.sv
// -----------------------------------------------------------------------------
// gcounter -- free-running WIDTH-bit reflected-binary Gray-code counter.
//
// Each clock advances the count by one, and exactly one bit of q toggles per
// cycle. The only state is the Gray register itself. The increment decodes the
// register to binary, adds one, and re-encodes it, all in a single
// combinational cone. There is no shadow binary register, so every flop that
// switches is a Gray bit.
//
// Parameters
//   WIDTH  counter/output width, legal range 2..64 (default 32)
//
// Ports
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous, active-high; clears q, has priority
//   q      out  WIDTH  registered Gray count
//   bin    out  WIDTH  binary equivalent of q, combinational
//                      (present only when GCOUNTER_BIN_EN is defined)
//
// Configuration macro
//   GCOUNTER_BIN_EN  when defined, exposes the internal Gray-to-binary value
//                    as port bin. This adds no state.
// -----------------------------------------------------------------------------
module gcounter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
`ifdef GCOUNTER_BIN_EN
    output logic [WIDTH-1:0] bin,
`endif
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] bin_w;
    logic [WIDTH-1:0] bin_inc;

    // Gray to binary. Bit i is the XOR of all Gray bits from i up to the MSB.
    // A reduction of the shifted word keeps each bit a flat function of q_q,
    // so there is no bit-to-bit chain inside one vector.
    always_comb begin
        bin_w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_w[i] = ^(q_q >> i);
        end
    end

    // The add wraps modulo 2^WIDTH by truncation.
    // Binary 2^WIDTH-1 (Gray 100..0) rolls over to 0.
    always_comb begin
        bin_inc = bin_w + {{(WIDTH-1){1'b0}}, 1'b1};
        q_d     = bin_inc ^ (bin_inc >> 1);
        if (reset) begin
            q_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

`ifdef GCOUNTER_BIN_EN
    assign bin = bin_w;
`endif

endmodule

// File: tb/tb_gcounter.sv
// -----------------------------------------------------------------------------
// tb_gcounter -- randomized self-checking bench for gcounter.
//
// Two instances share one clock and one reset:
//   dut_w  WIDTH=32, the default width
//   dut_n  WIDTH=4, which wraps every 16 counts
// The reference model is a plain integer count of edges since the last reset.
// Expected Gray values come from that integer as n ^ (n >> 1).
// -----------------------------------------------------------------------------
module tb_gcounter;

    localparam int WW = 32;
    localparam int WN = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [WW-1:0] q_w;
    logic [WN-1:0] q_n;
`ifdef GCOUNTER_BIN_EN
    logic [WW-1:0] bin_w;
    logic [WN-1:0] bin_n;
`endif

    int total = 0;
    int bad   = 0;

    longint unsigned n = 0;           // model: counts since last reset
    logic [WW-1:0]   prev_w;
    logic [WN-1:0]   prev_n;
    bit              prev_ok = 1'b0;  // prev_* holds a post-reset value

    always #5 clk = ~clk;

    gcounter #(.WIDTH(WW)) dut_w (
        .clk   (clk),
        .reset (reset),
`ifdef GCOUNTER_BIN_EN
        .bin   (bin_w),
`endif
        .q     (q_w)
    );

    gcounter #(.WIDTH(WN)) dut_n (
        .clk   (clk),
        .reset (reset),
`ifdef GCOUNTER_BIN_EN
        .bin   (bin_n),
`endif
        .q     (q_n)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (n=%0d)", tag, got, exp, n);
        end
    endtask

    function automatic longint unsigned gray(input longint unsigned v);
        return v ^ (v >> 1);
    endfunction

    // Gray to binary via a bit-serial prefix XOR, used for the B(q) check.
    function automatic longint unsigned ungray(input longint unsigned g);
        longint unsigned b = 0;
        for (int i = 63; i >= 0; i--) begin
            b[i] = g[i] ^ ((i == 63) ? 1'b0 : b[i+1]);
        end
        return b;
    endfunction

    // Apply one clock edge with the given reset level, update the model,
    // and check both instances.
    task automatic step(input bit rst);
        longint unsigned ew;
        longint unsigned en;
        @(negedge clk);
        reset = rst;
        @(posedge clk);
        #1;
        if (rst) n = 0;
        else     n = n + 1;
        ew = gray(n % (64'd1 << WW));
        en = gray(n % (64'd1 << WN));
        chk("q_w", 64'(q_w), ew);
        chk("q_n", 64'(q_n), en);
`ifdef GCOUNTER_BIN_EN
        chk("bin_w", 64'(bin_w), n % (64'd1 << WW));
        chk("bin_n", 64'(bin_n), n % (64'd1 << WN));
`endif
        if (!rst && prev_ok) begin
            chk("onehot_w", 64'($countones(q_w ^ prev_w)), 64'd1);
            chk("onehot_n", 64'($countones(q_n ^ prev_n)), 64'd1);
        end
        if (!rst && n % 16 == 0) begin
            chk("wrap_n_prev", 64'(prev_n), 64'h8);
            chk("wrap_n", 64'(q_n), 64'h0);
        end
        if (!rst && n == 200) begin
            chk("c200_q", 64'(q_w), 64'hAC);
            chk("c200_B", ungray(64'(q_w)), 64'd200);
        end
        prev_w  = q_w;
        prev_n  = q_n;
        prev_ok = 1'b1;
    endtask

    initial begin
        // Hold reset for three edges; q must read 0 after each one.
        for (int i = 0; i < 3; i++) step(1'b1);

        // Release reset and count 200 edges.
        // The first edge after release must give 1, not 0.
        step(1'b0);
        chk("first_after_rst", 64'(q_w), 64'h1);
        for (int i = 1; i < 200; i++) step(1'b0);

        // Reset at count 57, then expect the restart sequence 1, 3, 2.
        step(1'b1);
        for (int i = 0; i < 57; i++) step(1'b0);
        chk("at57", 64'(q_w), 64'h25);
        step(1'b1);
        chk("rst57", 64'(q_w), 64'h0);
        step(1'b0); chk("restart1", 64'(q_w), 64'h1);
        step(1'b0); chk("restart3", 64'(q_w), 64'h3);
        step(1'b0); chk("restart2", 64'(q_w), 64'h2);

        // Random phase: random reset pulses mixed with runs of counting.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 39) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
